sequence_detector_1001: RTL and testbench

//   Serial bit-pattern detector. Samples one bit of `in` per clk rising edge and pulses `out`
//   for one cycle each time the last PATTERN_LEN sampled bits equal PATTERN (default 1001).

---
 rtl/seq_det_pkg.sv | 39 +++
 rtl/seq_det_next.sv | 18 +
 rtl/sequence_detector_1001.sv | 37 +++
 tb/tb_sequence_detector_1001.sv | 99 +++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and elaboration-time KMP tables for the serial pattern detector
package seq_det_pkg;
  localparam int DEFAULT_PATTERN_LEN = 4;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1001;
  function automatic int state_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction
  // Entry q is the failure link for a matched prefix of length q; pattern bit i is pat[len-1-i].
  function automatic logic [16:0][4:0] failure_table(input logic [15:0] pat, input int len);
    logic [16:0][4:0] f;
    int k;
    f = '0;
    k = 0;
    for (int i = 1; i < len; i++) begin
      while (k > 0 && pat[4'(len-1-i)] != pat[4'(len-1-k)]) k = int'(f[5'(k)]);
      if (pat[4'(len-1-i)] == pat[4'(len-1-k)]) k++;
      f[5'(i+1)] = 5'(k);
    end
    return f;
  endfunction
  // Full transition table [state][bit], with the match wrap-around already folded in.
  function automatic logic [16:0][1:0][4:0] next_table(input logic [15:0] pat, input int len, input bit overlap);
    logic [16:0][4:0] f;
    logic [16:0][1:0][4:0] t;
    int k;
    f = failure_table(pat, len);
    t = '0;
    for (int s = 0; s < len; s++) begin
      for (int b = 0; b < 2; b++) begin
        k = s;
        while (k > 0 && int'(pat[4'(len-1-k)]) != b) k = int'(f[5'(k)]);
        if (int'(pat[4'(len-1-k)]) == b) k++;
        if (k == len) k = overlap ? int'(f[5'(len)]) : 0;
        t[5'(s)][b] = 5'(k);
      end
    end
    return t;
  endfunction
endpackage

// File: rtl/seq_det_next.sv
// seq_det_next: combinational next-state and match decode from a constant transition table
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int PATTERN_LEN = DEFAULT_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN = DEFAULT_PATTERN,
  parameter bit OVERLAP = 1'b1,
  parameter int SW = state_width(PATTERN_LEN)
) (
  input  logic [SW-1:0] state,
  input  logic          in,
  output logic [SW-1:0] next_state,
  output logic          match
);
  localparam logic [16:0][1:0][4:0] TRANS = next_table(16'(PATTERN), PATTERN_LEN, OVERLAP);
  assign next_state = TRANS[5'(state)][in][SW-1:0];
  assign match = (state == SW'(PATTERN_LEN-1)) && (in == PATTERN[0]);
endmodule

// File: rtl/sequence_detector_1001.sv
// sequence_detector_1001: serial sync-word spotter, registered one-cycle pulse per pattern match
module sequence_detector_1001
  import seq_det_pkg::*;
#(
  parameter int PATTERN_LEN = DEFAULT_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN = DEFAULT_PATTERN,
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);
  localparam int SW = state_width(PATTERN_LEN);
  logic [SW-1:0] state, next_state;
  logic match;
  seq_det_next #(
    .PATTERN_LEN(PATTERN_LEN),
    .PATTERN(PATTERN),
    .OVERLAP(OVERLAP),
    .SW(SW)
  ) u_next (
    .state(state),
    .in(in),
    .next_state(next_state),
    .match(match)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= '0;
      out <= 1'b0;
    end else begin
      state <= next_state;
      out <= match;
    end
  end
endmodule

// File: tb/tb_sequence_detector_1001.sv
// tb_sequence_detector_1001: scoreboard bench over overlapping, non-overlapping and 2'b11 detectors
module tb_sequence_detector_1001;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in = 1'b0;
  logic out_ov, out_nov, out_11;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic e_ov;
    logic e_nov;
    logic e_11;
    logic [7:0] phase;
  } exp_t;
  exp_t exp_q[$];
  logic [15:0] h_ov = '0, h_nov = '0, h_11 = '0;
  int c_ov = 0, c_nov = 0, c_11 = 0;
  always #5 clk = ~clk;
  sequence_detector_1001 dut_ov (.clk(clk), .reset(reset), .in(in), .out(out_ov));
  sequence_detector_1001 #(.OVERLAP(1'b0)) dut_nov (.clk(clk), .reset(reset), .in(in), .out(out_nov));
  sequence_detector_1001 #(.PATTERN_LEN(2), .PATTERN(2'b11)) dut_11 (.clk(clk), .reset(reset), .in(in), .out(out_11));
  // Reference: shift register plus count of bits usable toward a match since reset/last non-overlapping match.
  task automatic model(input bit r, input bit b, input int len, input logic [15:0] pat, input bit ovl,
                       inout logic [15:0] h, inout int c, output bit m);
    logic [15:0] mask;
    mask = 16'((32'd1 << len) - 1);
    m = 1'b0;
    if (!r) begin
      h = '0;
      c = 0;
    end else begin
      h = {h[14:0], b};
      c++;
      if (c >= len && (h & mask) == pat) begin
        m = 1'b1;
        if (!ovl) c = 0;
      end
    end
  endtask
  // hand_ov/hand_nov < 0 means take the reference model's value for the 1001 detectors.
  task automatic step(input int ph, input bit r, input bit b, input int hand_ov, input int hand_nov);
    bit m_ov, m_nov, m_11;
    exp_t e;
    @(negedge clk);
    reset = r;
    in = b;
    model(r, b, 4, 16'h9, 1'b1, h_ov, c_ov, m_ov);
    model(r, b, 4, 16'h9, 1'b0, h_nov, c_nov, m_nov);
    model(r, b, 2, 16'h3, 1'b1, h_11, c_11, m_11);
    e.e_ov = (hand_ov < 0) ? m_ov : hand_ov[0];
    e.e_nov = (hand_nov < 0) ? m_nov : hand_nov[0];
    e.e_11 = m_11;
    e.phase = 8'(ph);
    exp_q.push_back(e);
  endtask
  task automatic run(input int ph, input int n, input logic [31:0] bits, input logic [31:0] x_ov, input logic [31:0] x_nov);
    for (int i = 0; i < n; i++) step(ph, 1'b1, bits[n-1-i], int'(x_ov[n-1-i]), int'(x_nov[n-1-i]));
  endtask
  task automatic check(input string name, input int ph, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s phase=%0d t=%0t got=%b expected=%b", name, ph, $time, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_overlap", int'(e.phase), out_ov, e.e_ov);
        check("out_no_overlap", int'(e.phase), out_nov, e.e_nov);
        check("out_pat11", int'(e.phase), out_11, e.e_11);
      end
    end
  end
  initial begin
    step(1, 1'b0, 1'b1, 0, 0);
    step(1, 1'b0, 1'b0, 0, 0);
    run(2, 11, 32'b10011001001, 32'b00010001001, 32'b00010001000);
    step(3, 1'b0, 1'b0, 0, 0);
    run(4, 12, 32'b101000111001, 32'b000000000001, 32'b000000000001);
    run(5, 3, 32'b100, 32'b000, 32'b000);
    step(5, 1'b0, 1'b1, 0, 0);
    run(5, 4, 32'b1001, 32'b0001, 32'b0001);
    for (int i = 0; i < 10000; i++) step(6, $urandom_range(63) != 0, 1'($urandom_range(1)), -1, -1);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
